sa_psum_deskew: RTL and testbench

- Output-side counterpart of the activation skew stage feeding the 16x16 systolic array.
- The array emits partial sums on its bottom edge with column j lagging column 0 by j cycles.
- This block removes that triangular skew so that one aligned row vector appears per output row.
- Aligned rows are buffered in a small FIFO and presented on a valid/ready stream toward the writeback / post-processing stage.

---
 rtl/sa_pkg.sv | 11 +
 rtl/sa_row_fifo.sv | 63 ++++++
 rtl/sa_psum_deskew.sv | 122 ++++++++++++
 tb/tb_sa_psum_deskew.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and sizes for the 16x16 systolic array datapath.
package sa_pkg;

   localparam int SA_N_SIZE     = 16;
   localparam int SA_DATA_W_OUT = 32;
   localparam int SA_FIFO_DEPTH = 4;

   typedef logic signed [31:0]   psum_t;
   typedef psum_t [SA_N_SIZE-1:0] psum_row_t;

endpackage

// File: rtl/sa_row_fifo.sv
// Single-clock FIFO of aligned psum rows. Pointers carry an extra wrap bit so
// full and empty can be told apart; the head is read combinationally from memory.
module sa_row_fifo
   import sa_pkg::*;
#(
   parameter int DEPTH = SA_FIFO_DEPTH,
   parameter int ROW_W = $bits(psum_row_t),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [ROW_W-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [ROW_W-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [ROW_W-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [ROW_W-1:0] r_last;
   logic             w_do_wr;
   logic             w_do_rd;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_count = r_wptr - r_rptr;

   // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
   assign w_do_rd = i_rd_en && !o_empty;
   assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

   // When empty the output keeps showing the last row that was consumed.
   assign o_rd_data = o_empty ? r_last : r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_last <= '0;
      end else begin
         if (w_do_wr) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_do_rd) begin
            r_rptr <= r_rptr + PTR_ONE;
            r_last <= r_mem[r_rptr[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_wr && !rst) begin
         r_mem[r_wptr[AW-1:0]] <= i_wr_data;
      end
   end

endmodule

// File: rtl/sa_psum_deskew.sv
// Removes the triangular column skew of the array's bottom-edge psums and queues
// aligned rows on a valid/ready stream. Build option: PSUM_DESKEW_RELU_EN clamps negative lanes to 0.
module sa_psum_deskew
   import sa_pkg::*;
#(
   parameter int N_SIZE     = SA_N_SIZE,
   parameter int DATA_W_OUT = SA_DATA_W_OUT,
   parameter int FIFO_DEPTH = SA_FIFO_DEPTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_SIZE-1:0][DATA_W_OUT-1:0]   psum_in,
   input  logic                                valid_in,
   output logic [N_SIZE-1:0][DATA_W_OUT-1:0]   row_out,
   output logic                                row_valid,
   input  logic                                row_ready,
   output logic [15:0]                         row_count,
   output logic                                overflow,
   output logic                                busy
);

   localparam int ROW_W = N_SIZE * DATA_W_OUT;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   logic [N_SIZE-1:0][DATA_W_OUT-1:0] w_lane_dly;
   logic [N_SIZE-1:0][DATA_W_OUT-1:0] r_align;
   logic [N_SIZE-1:0][DATA_W_OUT-1:0] w_fifo_din;
   logic [N_SIZE-1:0]                 r_vpipe;
   logic                              w_aligned_vld;
   logic                              w_fifo_full;
   logic                              w_fifo_empty;
   logic [CW-1:0]                     w_fifo_count;
   logic [ROW_W-1:0]                  w_rd_data;
   logic                              w_pop;
   logic [15:0]                       r_row_count;
   logic                              r_overflow;

   // Lane j arrives j cycles after lane 0, so it is held N_SIZE-1-j cycles to line up.
   for (genvar j = 0; j < N_SIZE; j++) begin : g_lane
      localparam int DLY = N_SIZE - 1 - j;
      if (DLY == 0) begin : g_pass
         assign w_lane_dly[j] = psum_in[j];
      end else begin : g_dly
         logic [DLY-1:0][DATA_W_OUT-1:0] r_dl;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_dl <= '0;
            end else begin
               r_dl[0] <= psum_in[j];
               for (int k = 1; k < DLY; k++) begin
                  r_dl[k] <= r_dl[k-1];
               end
            end
         end
         assign w_lane_dly[j] = r_dl[DLY-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vpipe <= '0;
         r_align <= '0;
      end else begin
         r_vpipe <= {r_vpipe[N_SIZE-2:0], valid_in};
         r_align <= w_lane_dly;
      end
   end

   assign w_aligned_vld = r_vpipe[N_SIZE-1];

`ifdef PSUM_DESKEW_RELU_EN
   always_comb begin
      w_fifo_din = r_align;
      for (int k = 0; k < N_SIZE; k++) begin
         if (r_align[k][DATA_W_OUT-1]) begin
            w_fifo_din[k] = '0;
         end
      end
   end
`else
   assign w_fifo_din = r_align;
`endif

   sa_row_fifo #(
      .DEPTH (FIFO_DEPTH),
      .ROW_W (ROW_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_aligned_vld),
      .i_wr_data (w_fifo_din),
      .i_rd_en   (row_ready),
      .o_rd_data (w_rd_data),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_count   (w_fifo_count)
   );

   assign row_out   = w_rd_data;
   assign row_valid = !w_fifo_empty;
   assign w_pop     = row_valid && row_ready;

   // The array cannot be stalled: a row arriving into a full FIFO with no read is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_count <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_pop) begin
            r_row_count <= r_row_count + 16'd1;
         end
         if (w_aligned_vld && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign row_count = r_row_count;
   assign overflow  = r_overflow;
   assign busy      = (|r_vpipe) || (w_fifo_count != '0);

endmodule

// File: tb/tb_sa_psum_deskew.sv
// Randomised scoreboard bench for sa_psum_deskew: rows are issued skewed, a queue
// model predicts which rows get buffered, and a monitor checks every handshake.
module tb_sa_psum_deskew;
   import sa_pkg::*;

   localparam int N     = 16;
   localparam int DEPTH = 4;
   localparam int MAXC  = 4096;

   logic                clk;
   logic                rstIn;
   logic [N-1:0][31:0]  psumIn;
   logic                validIn;
   logic [N-1:0][31:0]  rowOut;
   logic                rowValid;
   logic                rowReady;
   logic [15:0]         rowCount;
   logic                overflowOut;
   logic                busyOut;

   int        nCompared = 0;
   int        nMismatch = 0;
   int        cyc = 0;
   bit        started = 0;
   psum_row_t histRow [MAXC];
   bit        histValid [MAXC];
   psum_row_t expq [$];
   int        occ = 0;
   logic      expOv = 0;
   logic [15:0] expCount = 0;
   int        validCycles = 0;
   bit        prevHold = 0;
   psum_row_t prevRow;

   sa_psum_deskew dut (
      .clk       (clk),
      .rst       (rstIn),
      .psum_in   (psumIn),
      .valid_in  (validIn),
      .row_out   (rowOut),
      .row_valid (rowValid),
      .row_ready (rowReady),
      .row_count (rowCount),
      .overflow  (overflowOut),
      .busy      (busyOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic psum_row_t randRow();
      psum_row_t r;
      for (int j = 0; j < N; j++) r[j] = psum_t'($urandom);
      return r;
   endfunction

   function automatic psum_row_t seqRow(input int base);
      psum_row_t r;
      for (int j = 0; j < N; j++) r[j] = psum_t'(base + j);
      return r;
   endfunction

   function automatic psum_row_t expRow(input psum_row_t r);
      psum_row_t e;
      e = r;
`ifdef PSUM_DESKEW_RELU_EN
      for (int j = 0; j < N; j++) if (e[j][31]) e[j] = '0;
`endif
      return e;
   endfunction

   // One cycle of stimulus: lane j carries lane j of the row issued j cycles ago.
   task automatic applyStimulus(input logic v, input psum_row_t r, input logic rdy, input logic rs);
      psum_row_t stored;
      @(posedge clk);
      #1;
      stored = v ? r : randRow();
      histRow[cyc] = stored;
      histValid[cyc] = v;
      validIn = v;
      rowReady = rdy;
      rstIn = rs;
      for (int j = 0; j < N; j++) psumIn[j] = (cyc >= j) ? histRow[cyc-j][j] : 32'd0;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rdy, 1'b0);
   endtask

   // Reference model: a row issued in cycle c reaches the buffer at the end of cycle c+N.
   always @(posedge clk) begin : modelBlk
      bit popNow;
      bit arrive;
      if (rstIn === 1'b1) begin
         occ = 0;
         expq.delete();
         expOv = 0;
         expCount = 0;
         for (int i = 0; i <= cyc; i++) histValid[i] = 0;
      end else begin
         popNow = (occ > 0) && (rowReady === 1'b1);
         arrive = (cyc >= N) && histValid[cyc-N];
         if (popNow) begin
            occ--;
            expCount++;
         end
         if (arrive) begin
            if (occ < DEPTH) begin
               occ++;
               expq.push_back(expRow(histRow[cyc-N]));
            end else begin
               expOv = 1;
            end
         end
      end
      started = 1;
      cyc++;
   end

   // Monitor: compares presented state every cycle and pops the scoreboard on each handshake.
   always @(negedge clk) begin : monitorBlk
      bit expBusy;
      if (started) begin
         checkOutput("rowValid", 512'(rowValid), 512'(occ > 0));
         checkOutput("overflow", 512'(overflowOut), 512'(expOv));
         checkOutput("rowCount", 512'(rowCount), 512'(expCount));
         expBusy = (occ > 0);
         for (int k = 1; k <= N; k++) if (cyc >= k && histValid[cyc-k]) expBusy = 1;
         checkOutput("busy", 512'(busyOut), 512'(expBusy));
         if (prevHold) begin
            checkOutput("holdValid", 512'(rowValid), 512'(1'b1));
            checkOutput("holdData", 512'(rowOut), 512'(prevRow));
         end
         if (rowValid === 1'b1 && rowReady === 1'b1) begin
            if (expq.size() == 0) begin
               nCompared++;
               nMismatch++;
               $display("[TB] FAIL unexpectedRow: got %0h, want no row (cycle %0d)", rowOut, cyc);
            end else begin
               checkOutput("rowData", 512'(rowOut), 512'(expq.pop_front()));
            end
         end
         if (rowValid === 1'b1) validCycles++;
         prevHold = (rowValid === 1'b1) && (rowReady === 1'b0) && (rstIn === 1'b0);
         prevRow = rowOut;
      end
   end

   initial begin
      int t0;
      int rise;
      int vc0;
      logic [15:0] rc0;
      psum_row_t reluRow;

      rstIn = 1'b1;
      validIn = 1'b0;
      rowReady = 1'b0;
      psumIn = '0;
      histRow[0] = '0;
      histValid[0] = 0;

      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("resetRowValid", 512'(rowValid), 512'(1'b0));
      checkOutput("resetRowOut", 512'(rowOut), 512'(0));
      checkOutput("resetRowCount", 512'(rowCount), 512'(0));
      checkOutput("resetOverflow", 512'(overflowOut), 512'(1'b0));
      checkOutput("resetBusy", 512'(busyOut), 512'(1'b0));

      $display("[TB] single row");
      applyStimulus(1'b1, seqRow(100), 1'b1, 1'b0);
      t0 = cyc;
      rise = -1;
      for (int k = 0; k < 40 && rise < 0; k++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         if (rowValid === 1'b1) rise = cyc;
      end
      checkOutput("singleLatency", 512'(rise - t0), 512'(N + 1));
      idle(4, 1'b1);
      checkOutput("singleCount", 512'(rowCount), 512'(1));
      checkOutput("singleBusyFalls", 512'(busyOut), 512'(1'b0));

      $display("[TB] back-to-back rows");
      vc0 = validCycles;
      for (int k = 0; k < 20; k++) applyStimulus(1'b1, seqRow(k * 16), 1'b1, 1'b0);
      idle(25, 1'b1);
      checkOutput("b2bValidCycles", 512'(validCycles - vc0), 512'(20));
      checkOutput("b2bOverflow", 512'(overflowOut), 512'(1'b0));

      $display("[TB] full with simultaneous read and write");
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, seqRow(32'h400 + k * 16), 1'b0, 1'b0);
      idle(N + 2, 1'b0);
      checkOutput("fillCount", 512'(dut.u_fifo.o_count), 512'(DEPTH));
      applyStimulus(1'b1, seqRow(32'h500), 1'b0, 1'b0);
      for (int k = 1; k <= N; k++) applyStimulus(1'b0, '0, (k == N), 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("simulOverflow", 512'(overflowOut), 512'(1'b0));
      checkOutput("simulCount", 512'(dut.u_fifo.o_count), 512'(DEPTH));
      idle(8, 1'b1);

      $display("[TB] backpressure");
      rc0 = rowCount;
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, seqRow(32'h600 + k * 16), 1'b0, 1'b0);
      idle(N + 2, 1'b0);
      checkOutput("bpOverflowSet", 512'(overflowOut), 512'(1'b1));
      checkOutput("bpCount", 512'(dut.u_fifo.o_count), 512'(DEPTH));
      idle(8, 1'b1);
      checkOutput("bpOverflowSticky", 512'(overflowOut), 512'(1'b1));
      checkOutput("bpDrained", 512'(16'(rowCount - rc0)), 512'(4));

      $display("[TB] reset mid-flight");
      applyStimulus(1'b1, seqRow(32'h700), 1'b1, 1'b0);
      idle(7, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("rstRowValid", 512'(rowValid), 512'(1'b0));
      checkOutput("rstRowOut", 512'(rowOut), 512'(0));
      checkOutput("rstRowCount", 512'(rowCount), 512'(0));
      checkOutput("rstOverflow", 512'(overflowOut), 512'(1'b0));
      checkOutput("rstBusy", 512'(busyOut), 512'(1'b0));
      vc0 = validCycles;
      idle(25, 1'b1);
      checkOutput("rstNoRow", 512'(validCycles - vc0), 512'(0));

      $display("[TB] alternating sign row");
      for (int j = 0; j < N; j++) reluRow[j] = (j % 2 == 0) ? psum_t'(-5) : psum_t'(7);
      applyStimulus(1'b1, reluRow, 1'b1, 1'b0);
      idle(20, 1'b1);

      $display("[TB] random traffic");
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'($urandom_range(0, 1)), randRow(), ($urandom_range(0, 3) != 0), 1'b0);
      end
      idle(30, 1'b1);
      checkOutput("allRowsEmitted", 512'(expq.size()), 512'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
